// File: rtl/muldiv_issue_ctrl_pkg.sv
// muldiv_issue_ctrl_pkg: shared funct codes, bus widths and issue FSM states
package muldiv_issue_ctrl_pkg;
    localparam int DATA_BUS = 32;
    localparam logic [5:0] FUNCT_MULT   = 6'h18;
    localparam logic [5:0] FUNCT_MULTU  = 6'h19;
    localparam logic [5:0] FUNCT_DIV    = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
    // SPECIAL2 ops live at 0x20-0x25 so none of them aliases the NOP value 0
    localparam logic [5:0] FUNCT2_MADD  = 6'h20;
    localparam logic [5:0] FUNCT2_MADDU = 6'h21;
    localparam logic [5:0] FUNCT2_MUL   = 6'h22;
    localparam logic [5:0] FUNCT2_MSUB  = 6'h24;
    localparam logic [5:0] FUNCT2_MSUBU = 6'h25;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE_WAIT, ST_DRAIN} md_state_e;
    function automatic logic writes_hilo(input logic [5:0] f);
        return f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                         FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU};
    endfunction
endpackage

// File: rtl/muldiv_issue_ctrl_hilo_regs.sv
// muldiv_issue_ctrl_hilo_regs: architectural HI/LO storage with WB forwarding
module muldiv_issue_ctrl_hilo_regs
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_BUS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_hi_we,
    input  logic                wb_lo_we,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                commit_we,
    input  logic [2*DATA_W-1:0] commit_data,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic [DATA_W-1:0]   md_hi,
    output logic [DATA_W-1:0]   md_lo
);
    // A commit beats a same-cycle MTHI/MTLO because the MT instruction is older
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            hi <= commit_we ? commit_data[2*DATA_W-1:DATA_W] : wb_hi_we ? wb_data : hi;
            lo <= commit_we ? commit_data[DATA_W-1:0] : wb_lo_we ? wb_data : lo;
        end
    end
    // Forward an in-flight MTHI/MTLO so madd/msub see the newest HI/LO
    always_comb begin
        md_hi = wb_hi_we ? wb_data : hi;
        md_lo = wb_lo_we ? wb_data : lo;
    end
endmodule

// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-stage issue/hold/commit control for the mult/div unit
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int DATA_W         = DATA_BUS,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                stall_in,
    input  logic                md_en,
    input  logic [5:0]          funct,
    input  logic [DATA_W-1:0]   operand_1,
    input  logic [DATA_W-1:0]   operand_2,
    input  logic                wb_hi_we,
    input  logic                wb_lo_we,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                md_done,
    input  logic [2*DATA_W-1:0] md_result,
    output logic [5:0]          md_funct,
    output logic [DATA_W-1:0]   md_op1,
    output logic [DATA_W-1:0]   md_op2,
    output logic [DATA_W-1:0]   md_hi,
    output logic [DATA_W-1:0]   md_lo,
    output logic                md_flush,
    output logic                stall_req,
    output logic                mul_valid,
    output logic [DATA_W-1:0]   mul_result,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    md_state_e           state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [2*DATA_W-1:0] result_buf;
    logic [2*DATA_W-1:0] commit_data;
    logic                issue;
    logic                busy_done;
    logic                commit;
    logic                timeout;
    logic                abort;
    logic                hilo_we;
    // Per-cycle issue/commit/abort decisions; a done in the first BUSY cycle is stale
    always_comb begin
        issue       = (state == ST_IDLE || state == ST_DRAIN) && md_en && !flush;
        busy_done   = state == ST_BUSY && md_done && wait_cnt != '0 && !flush;
        commit      = !stall_in && (busy_done || (state == ST_DONE_WAIT && !flush));
        timeout     = state == ST_BUSY && !flush && !busy_done && wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        abort       = timeout || (flush && (state == ST_BUSY || state == ST_DONE_WAIT));
        commit_data = state == ST_DONE_WAIT ? result_buf : md_result;
        stall_req   = state == ST_IDLE ? md_en && !flush : state == ST_DRAIN ? md_en : !commit;
        mul_valid   = commit && md_funct == FUNCT2_MUL;
        mul_result  = commit_data[DATA_W-1:0];
        hilo_we     = commit && writes_hilo(md_funct);
    end
    // Issue FSM: latch the op at issue, hold it until DRAIN, park results stalled downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            md_funct    <= '0;
            md_op1      <= '0;
            md_op2      <= '0;
            md_flush    <= 1'b0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
            result_buf  <= '0;
        end else begin
            md_flush <= abort;
            if (timeout)
                err_timeout <= 1'b1;
            if (issue) begin
                state    <= ST_BUSY;
                md_funct <= funct;
                md_op1   <= operand_1;
                md_op2   <= operand_2;
                wait_cnt <= '0;
            end else if (busy_done && stall_in) begin
                state      <= ST_DONE_WAIT;
                result_buf <= md_result;
            end else if (commit || abort) begin
                state    <= ST_DRAIN;
                md_funct <= '0;
            end else if (state == ST_DRAIN) begin
                state <= ST_IDLE;
            end else if (state == ST_BUSY) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end
    muldiv_issue_ctrl_hilo_regs #(.DATA_W(DATA_W)) u_hilo (
        .clk         (clk),
        .rst         (rst),
        .wb_hi_we    (wb_hi_we),
        .wb_lo_we    (wb_lo_we),
        .wb_data     (wb_data),
        .commit_we   (hilo_we),
        .commit_data (commit_data),
        .hi          (hi),
        .lo          (lo),
        .md_hi       (md_hi),
        .md_lo       (md_lo)
    );
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// tb_muldiv_issue_ctrl: transaction-level randomized check of the mult/div issue controller
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;
    localparam int W   = 32;
    localparam int TMO = 64;
    logic          clk = 1'b0, rst = 1'b1, flush = 1'b0, stall_in = 1'b0, md_en = 1'b0;
    logic          wb_hi_we = 1'b0, wb_lo_we = 1'b0, md_done = 1'b0;
    logic [5:0]    funct = '0;
    logic [W-1:0]  operand_1 = '0, operand_2 = '0, wb_data = '0;
    logic [2*W-1:0] md_result = '0;
    logic [5:0]    md_funct;
    logic [W-1:0]  md_op1, md_op2, md_hi, md_lo, mul_result, hi, lo;
    logic          md_flush, stall_req, mul_valid, err_timeout;
    int            errors = 0, checks = 0;
    logic [W-1:0]  m_hi = '0, m_lo = '0;
    logic          m_err = 1'b0, exp_mdflush = 1'b0, in_drain = 1'b0, wb_rand = 1'b0;
    logic [5:0]    codes [9] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT2_MUL,
                                 FUNCT2_MADD, FUNCT2_MADDU, FUNCT2_MSUB, FUNCT2_MSUBU};

    muldiv_issue_ctrl #(.DATA_W(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in), .md_en(md_en), .funct(funct),
        .operand_1(operand_1), .operand_2(operand_2), .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
        .wb_data(wb_data), .md_done(md_done), .md_result(md_result), .md_funct(md_funct),
        .md_op1(md_op1), .md_op2(md_op2), .md_hi(md_hi), .md_lo(md_lo), .md_flush(md_flush),
        .stall_req(stall_req), .mul_valid(mul_valid), .mul_result(mul_result), .hi(hi), .lo(lo),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // What the mult/div unit would produce for an op, from plain arithmetic
    function automatic logic [63:0] calc(input logic [5:0] f, input logic [31:0] a, b, h, l);
        longint sa, sb;
        logic [63:0] ua, ub, hl, sp, up;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        hl = {h, l};
        sp = 64'(sa * sb);
        up = ua * ub;
        case (f)
            FUNCT_MULT, FUNCT2_MUL: return sp;
            FUNCT_MULTU:  return up;
            FUNCT_DIV:    return {32'(sa % sb), 32'(sa / sb)};
            FUNCT_DIVU:   return {32'(ua % ub), 32'(ua / ub)};
            FUNCT2_MADD:  return hl + sp;
            FUNCT2_MADDU: return hl + up;
            FUNCT2_MSUB:  return hl - sp;
            FUNCT2_MSUBU: return hl - up;
            default:      return '0;
        endcase
    endfunction

    task automatic rand_wb();
        wb_hi_we = wb_rand && ($urandom_range(0, 5) == 0);
        wb_lo_we = wb_rand && ($urandom_range(0, 5) == 0);
        wb_data  = $urandom;
    endtask

    task automatic common_chk();
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("md_hi", md_hi, wb_hi_we ? wb_data : m_hi);
        chk("md_lo", md_lo, wb_lo_we ? wb_data : m_lo);
        chk("md_flush", md_flush, exp_mdflush);
        chk("err_timeout", err_timeout, m_err);
    endtask

    task automatic wb_apply(input logic c, input logic [63:0] r);
        m_hi = c ? r[63:32] : wb_hi_we ? wb_data : m_hi;
        m_lo = c ? r[31:0] : wb_lo_we ? wb_data : m_lo;
    endtask

    // A cycle with no op issued (en implies fl so nothing may start)
    task automatic idle_cycle(input logic en, input logic fl, input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        md_en = en; flush = fl; md_done = 1'($urandom); stall_in = 1'($urandom);
        funct = codes[$urandom_range(0, 8)]; operand_1 = $urandom; operand_2 = $urandom;
        wb_hi_we = whi; wb_lo_we = wlo; wb_data = d;
        #1;
        common_chk();
        chk("idle_funct", md_funct, 6'd0);
        chk("idle_stall", stall_req, in_drain ? en : en && !fl);
        chk("idle_mul_valid", mul_valid, 1'b0);
        wb_apply(1'b0, '0);
        exp_mdflush = 1'b0;
        in_drain = 1'b0;
    endtask

    // One op: issue cycle, then BUSY/DONE_WAIT cycles until commit, flush or timeout
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, b, input int lat, stl, fl,
                          input logic nodone, input logic mt);
        logic [63:0] res;
        logic fls, cm, to, ab;
        int k;
        res = calc(f, a, b, m_hi, m_lo);
        @(negedge clk);
        md_en = 1'b1; funct = f; operand_1 = a; operand_2 = b; flush = 1'b0; stall_in = 1'b0;
        md_done = 1'b0; md_result = {$urandom, $urandom}; rand_wb();
        #1;
        common_chk();
        chk("issue_stall", stall_req, 1'b1);
        chk("issue_funct", md_funct, 6'd0);
        wb_apply(1'b0, '0);
        exp_mdflush = 1'b0;
        k = 0;
        do begin
            k++;
            @(negedge clk);
            funct = 6'($urandom); operand_1 = $urandom; operand_2 = $urandom;
            md_done = (!nodone && k >= lat) || k == 1;
            md_result = k == lat ? res : {$urandom, $urandom};
            stall_in = k >= lat ? (k < lat + stl) : 1'($urandom);
            fls = k == fl;
            flush = fls;
            rand_wb();
            cm = !fls && !nodone && k == lat + stl;
            if (mt && cm) begin
                wb_hi_we = 1'b0; wb_lo_we = 1'b1; wb_data = 32'hAAAA;
            end
            to = !fls && nodone && k == TMO;
            ab = fls || to;
            #1;
            common_chk();
            chk("busy_funct", md_funct, f);
            chk("busy_op1", md_op1, a);
            chk("busy_op2", md_op2, b);
            chk("busy_stall", stall_req, !cm);
            chk("mul_valid", mul_valid, cm && f == FUNCT2_MUL);
            if (cm && f == FUNCT2_MUL)
                chk("mul_result", mul_result, res[31:0]);
            wb_apply(cm && f != FUNCT2_MUL, res);
            exp_mdflush = ab;
            if (to) m_err = 1'b1;
        end while (!(cm || ab));
        in_drain = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_funct", md_funct, 6'd0);
        chk("rst_op1", md_op1, 32'd0);
        chk("rst_op2", md_op2, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_md_flush", md_flush, 1'b0);
        chk("rst_mul_valid", mul_valid, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_stall", stall_req, 1'b0);
        rst = 1'b0;
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_op(FUNCT_MULT, 32'd3, 32'hFFFFFFFE, 6, 0, 0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
        run_op(FUNCT_DIV, 32'd7, 32'hFFFFFFFE, 17, 0, 0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("div_hi", hi, 32'h1);
        chk("div_lo", lo, 32'hFFFFFFFD);
        run_op(FUNCT_MULTU, 32'd5, 32'd5, 4, 0, 0, 1'b0, 1'b0);
        run_op(FUNCT_MULTU, 32'd5, 32'd5, 5, 0, 0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("multu_lo", lo, 32'd25);
        idle_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234);
        run_op(FUNCT_DIV, 32'd100, 32'd7, 12, 0, 5, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("flush_hi", hi, 32'h1234);
        chk("flush_lo", lo, 32'h1234);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_op(FUNCT_MULT, 32'd2, 32'd4, 4, 3, 0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("dw_lo", lo, 32'd8);
        run_op(FUNCT2_MUL, 32'h55, 32'd1, 3, 0, 0, 1'b0, 1'b1);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("mul_mtlo_lo", lo, 32'hAAAA);
        run_op(FUNCT_MULT, 32'h55, 32'd1, 3, 0, 0, 1'b0, 1'b1);
        idle_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("mult_mtlo_lo", lo, 32'h55);
        idle_cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        run_op(FUNCT_MULTU, 32'd9, 32'd9, 1000, 0, 0, 1'b1, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("err_sticky", err_timeout, 1'b1);
        wb_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [5:0] f;
            logic [31:0] a, b;
            logic en;
            int lat, stl, fl;
            f = codes[$urandom_range(0, 8)];
            a = $urandom;
            b = $urandom;
            if (f == FUNCT_DIV || f == FUNCT_DIVU) begin
                b = $urandom_range(1, 1000);
                if (f == FUNCT_DIV && $urandom_range(0, 1) == 1) b = -b;
            end
            lat = $urandom_range(2, 20);
            stl = $urandom_range(0, 2) == 0 ? $urandom_range(1, 4) : 0;
            fl  = $urandom_range(0, 5) == 0 ? $urandom_range(1, lat + stl) : 0;
            run_op(f, a, b, lat, stl, fl, 1'b0, $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                en = 1'($urandom);
                idle_cycle(en, en | 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            end
        end
        wb_rand = 1'b0;
        idle_cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD);
        @(negedge clk);
        md_en = 1'b1; funct = FUNCT_DIV; operand_1 = 32'd50; operand_2 = 32'd5;
        flush = 1'b0; stall_in = 1'b0; md_done = 1'b0; wb_hi_we = 1'b0; wb_lo_we = 1'b0;
        @(negedge clk);
        md_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_funct", md_funct, 6'd0);
        chk("midrst_op1", md_op1, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_err", err_timeout, 1'b0);
        chk("midrst_stall", stall_req, 1'b0);
        m_hi = '0; m_lo = '0; m_err = 1'b0; exp_mdflush = 1'b0; in_drain = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        run_op(FUNCT2_MADD, 32'd6, 32'd7, 5, 1, 0, 1'b0, 1'b0);
        idle_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("madd_lo", lo, 32'd42);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- EX-stage requester for the multiply/divide unit: issues mult/div/madd/msub ops, holds them stable until `md_done`, then commits the 64-bit result.
- Owns the architectural HI/LO registers and generates the EX stall request.
- Returns to NOP for at least one cycle between operations, so an identical back-to-back funct is re-issued rather than seen as already done.
- Sits between the EX-stage operand mux, the mult/div datapath and the pipeline stall/flush control.

Parameters:
- DATA_W, 32, operand/HI/LO width; the result is 2*DATA_W.
- TIMEOUT_CYCLES, 64, maximum BUSY cycles before the op is aborted and err_timeout is raised.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  squash the instruction in EX
- stall_in  in  1  downstream stall; EX result cannot retire this cycle
- md_en  in  1  EX holds a mult/div-class instruction
- funct  in  6  unit funct code (FUNCT_MULT/MULTU/DIV/DIVU, FUNCT2_MUL/MADD/MADDU/MSUB/MSUBU)
- operand_1, operand_2  in  DATA_W  source operands
- wb_hi_we, wb_lo_we  in  1  MTHI/MTLO write from WB
- wb_data  in  DATA_W  MTHI/MTLO data
- md_done  in  1  done from mult/div unit
- md_result  in  2*DATA_W  {hi,lo} result from unit
- md_funct  out  6  funct driven to unit; 0 = NOP
- md_op1, md_op2  out  DATA_W  latched operands to unit
- md_hi, md_lo  out  DATA_W  forwarded HI/LO to unit (for madd/msub)
- md_flush  out  1  abort pulse to unit
- stall_req  out  1  stall IF/ID/EX
- mul_valid  out  1  1-cycle pulse: mul_result is the rd value (FUNCT2_MUL)
- mul_result  out  DATA_W  low word of result for MUL
- hi, lo  out  DATA_W  architectural HI/LO
- err_timeout  out  1  sticky abort flag

Behaviour:
- Reset values (async): state IDLE, hi=lo=0, md_funct=0, md_op1/md_op2=0, md_flush=0, mul_valid=0, err_timeout=0, wait counter 0.
- States:
  - IDLE
    - md_funct=0.
    - If md_en && !flush: latch funct/operands, go BUSY; stall_req=1 this same cycle (combinational on md_en).
    - Otherwise stall_req=0.
  - BUSY
    - md_funct = latched funct; stall_req=1; wait counter increments.
    - md_done is ignored in the first BUSY cycle.
    - On md_done && !flush && !stall_in: commit, stall_req=0 this cycle, go DRAIN.
    - On md_done && stall_in: capture md_result into result_buf, go DONE_WAIT.
  - DONE_WAIT
    - md_funct = latched funct; stall_req=1.
    - When !stall_in: commit from result_buf, stall_req=0, go DRAIN.
  - DRAIN
    - md_funct=0 for exactly this cycle; stall_req=md_en.
    - If md_en && !flush: latch the new op, go BUSY; else go IDLE.
- Commit:
  - MULT/MULTU/DIV/DIVU/MADD*/MSUB*: hi<=result[63:32], lo<=result[31:0].
  - MUL: hi/lo unchanged; mul_valid=1 and mul_result=result[31:0] in the commit cycle.
- Flush:
  - In BUSY or DONE_WAIT: md_flush=1 for one cycle, no commit, go DRAIN.
  - Flush wins over a simultaneous md_done.
  - In IDLE/DRAIN: md_en is ignored.
- Timeout:
  - If the wait counter reaches TIMEOUT_CYCLES in BUSY: err_timeout<=1 (sticky until reset), md_flush pulse, go DRAIN, no commit.
  - Counter clears on every issue.
- WB writes:
  - wb_hi_we/wb_lo_we update hi/lo in any state.
  - When coinciding with a commit, the commit value wins (MT is older).
- Forwarding: md_hi = wb_hi_we ? wb_data : hi; md_lo likewise; combinational every cycle.
- Operands and funct are held constant from issue until the DRAIN cycle regardless of the EX inputs.
- Reset mid-operation: returns to IDLE immediately; no commit.

Decomposition:
- Funct codes come from the shared funct include; DATA_BUS/DOUBLE_DATA_BUS widths from the bus include.
- State encoding (IDLE/BUSY/DONE_WAIT/DRAIN) goes in the shared include as localparams.
- One sub-module: hilo_regs (HI/LO storage, WB-vs-commit priority, md_hi/md_lo forwarding).

Test Plan:
- MULT 3 × 0xFFFFFFFE -> after done: hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_req high from the issue cycle until the commit cycle; then one DRAIN cycle with md_funct=0.
- DIV 7 / 0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=0x00000001; stall spans ≥17 cycles.
- Two consecutive MULTU 5×5 -> second op sees md_funct=0 for one cycle in between and commits lo=25 only after its own done; no instant completion.
- Flush 5 cycles into a DIV with hi=lo=0x1234 -> md_flush pulse, hi/lo remain 0x1234, state DRAIN then IDLE.
- stall_in held 3 cycles when md_done rises on MULT 2×4 -> DONE_WAIT, commit lo=8 on the first cycle with stall_in=0.
- MTLO 0xAAAA in WB on the same cycle as MUL commit (result 0x55) -> lo=0xAAAA, mul_valid=1, mul_result=0x55. Same with MULT (result lo 0x55) -> lo=0x55.
